// File: rtl/t01_btn_pkg.sv
// t01_btn_pkg: shared scheduler state type and width helper for the button event controller
package t01_btn_pkg;
  typedef enum logic {IDLE, OFFER} sched_state_e;
  function automatic int w_of(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/t01_btn_filter.sv
// t01_btn_filter: 2-flop synchronizer plus stable-count debounce with a one-cycle press pulse
module t01_btn_filter
  import t01_btn_pkg::*;
#(
  parameter int STABLE_TICKS = 3
) (
  input  logic clk,
  input  logic nrst,
  input  logic tick,
  input  logic pb,
  output logic btn_state,
  output logic press
);
  localparam int CW = w_of(STABLE_TICKS + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic flip;
  assign flip = tick && (sync[1] != btn_state) && (cnt == LAST);
  assign press = flip && !btn_state;
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      sync <= '0;
      cnt <= '0;
      btn_state <= 1'b0;
    end else begin
      sync <= {sync[0], pb};
      if (tick) cnt <= (sync[1] == btn_state || flip) ? '0 : cnt + 1'b1;
      if (flip) btn_state <= !btn_state;
    end
endmodule

// File: rtl/t01_button_event_ctrl.sv
// t01_button_event_ctrl: shared tick divider, per-button debounce and round-robin press event port
module t01_button_event_ctrl
  import t01_btn_pkg::*;
#(
  parameter int N_BTN        = 4,
  parameter int TICK_DIV     = 250000,
  parameter int STABLE_TICKS = 3
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    en,
  input  logic [N_BTN-1:0]        pb,
  output logic [N_BTN-1:0]        btn_state,
  output logic                    evt_valid,
  output logic [w_of(N_BTN)-1:0]  evt_id,
  input  logic                    evt_ready,
  output logic                    overrun
);
  localparam int IW = w_of(N_BTN);
  localparam int TW = w_of(TICK_DIV);
  logic [TW-1:0] tcnt;
  logic tick;
  logic [N_BTN-1:0] press, pending, clr;
  logic [IW-1:0] rr_ptr, rr_d, id_d, pick;
  logic found, accept;
  int j;
  sched_state_e state, state_d;
  assign tick = en && (tcnt == TW'(TICK_DIV - 1));
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) tcnt <= '0;
    else tcnt <= (!en || tick) ? '0 : tcnt + 1'b1;
  for (genvar g = 0; g < N_BTN; g++) begin : g_flt
    t01_btn_filter #(.STABLE_TICKS(STABLE_TICKS)) u_flt (
      .clk(clk), .nrst(nrst), .tick(tick), .pb(pb[g]),
      .btn_state(btn_state[g]), .press(press[g])
    );
  end
  assign evt_valid = (state == OFFER);
  assign accept = evt_valid && evt_ready;
  assign clr = accept ? (N_BTN'(1) << evt_id) : '0;
  // Scan downward so the nearest set bit at or after rr_ptr is the last one written.
  always_comb begin
    pick = '0;
    found = 1'b0;
    j = 0;
    for (int k = N_BTN - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      if (j >= N_BTN) j -= N_BTN;
      if (pending[j]) begin
        found = 1'b1;
        pick = IW'(j);
      end
    end
  end
  always_comb begin
    state_d = state;
    id_d = evt_id;
    rr_d = rr_ptr;
    if (state == IDLE && found) begin
      state_d = OFFER;
      id_d = pick;
    end else if (accept) begin
      state_d = IDLE;
      rr_d = (evt_id == IW'(N_BTN - 1)) ? '0 : evt_id + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      state <= IDLE;
      evt_id <= '0;
      rr_ptr <= '0;
      pending <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_d;
      evt_id <= id_d;
      rr_ptr <= rr_d;
      pending <= (pending & ~clr) | press;
      overrun <= |(press & pending & ~clr);
    end
endmodule
